// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported, variable-latency memory
// between instruction fetch and load/store. One access in flight at a time;
// data has fixed priority over fetch. Hung accesses are aborted after
// TIMEOUT_CYCLES and reported with err.
// Optional feature macro: ARB_STARVE_LIMIT_EN -- after MAX_DATA_BURST
// consecutive data grants a pending fetch is granted ahead of data.
module unified_mem_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_D  = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    // Last count value before abort: counter starts at 0 on accept, so the
    // request is held for exactly TIMEOUT_CYCLES cycles.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    logic [TW-1:0] to_cnt;
    logic          grant_ok;
    logic          force_if;

`ifdef ARB_STARVE_LIMIT_EN
    localparam int            BW        = $clog2(MAX_DATA_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

    logic [BW-1:0] burst_cnt;

    // Count consecutive data grants (saturating); any fetch grant restarts the run.
    always_ff @(posedge clk) begin
        if (reset)
            burst_cnt <= '0;
        else if (if_gnt)
            burst_cnt <= '0;
        else if (d_gnt && burst_cnt != BURST_MAX)
            burst_cnt <= burst_cnt + 1'b1;
    end

    assign force_if = if_req && (burst_cnt == BURST_MAX);
`else
    logic unused_cfg;
    assign unused_cfg = ^MAX_DATA_BURST;
    assign force_if   = 1'b0;
`endif

    // Grants only in IDLE; gated by reset so every output reads 0 during reset.
    assign grant_ok = !reset && (state == IDLE);
    assign d_gnt    = grant_ok && d_req && !force_if;
    assign if_gnt   = grant_ok && if_req && !d_gnt;

    // Request FSM: accept, hold mem_* until ack or timeout, respond, recover.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            to_cnt    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_gnt) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        to_cnt    <= '0;
                        state     <= BUSY_D;
                    end else if (if_gnt) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        to_cnt    <= '0;
                        state     <= BUSY_IF;
                    end
                end
                BUSY_IF, BUSY_D: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        rdata     <= mem_we ? '0 : mem_rdata;
                        err       <= 1'b0;
                        if_rvalid <= (state == BUSY_IF);
                        d_rvalid  <= (state == BUSY_D);
                        state     <= RESP;
                    end else if (to_cnt == TO_LAST) begin
                        mem_req   <= 1'b0;
                        rdata     <= '0;
                        err       <= 1'b1;
                        if_rvalid <= (state == BUSY_IF);
                        d_rvalid  <= (state == BUSY_D);
                        state     <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if_rvalid <= 1'b0;
                    d_rvalid  <= 1'b0;
                    err       <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: memory responder model, per-owner response
// scoreboards, grant-order log. Honours ARB_STARVE_LIMIT_EN for expectations.
module tb_unified_mem_arbiter;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [63:0] if_addr;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [63:0] d_addr, d_wdata, rdata;
    logic        err, mem_req, mem_we, mem_ack;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    resp_t exp_if[$];
    resp_t exp_d[$];

    logic       ack_r, spur_ack, ack_en;
    int         ack_lat, lat_cnt;
    logic [7:0] seq = '0;
    int         gcnt = 0, reqcnt = 0;
    logic       overlap = 1'b0;

    unified_mem_arbiter #(
        .ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(8), .MAX_DATA_BURST(4)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] a);
        if (a == 64'h100) return 64'h0000_0000_0050_0093;
        return {~a[31:0], a[31:0]};
    endfunction

    // Memory responder: acks after ack_lat extra cycles of observed mem_req.
    assign mem_ack = ack_r | spur_ack;
    always @(posedge clk) begin
        if (reset) begin
            ack_r     <= 1'b0;
            lat_cnt   <= 0;
            mem_rdata <= '0;
        end else if (mem_req && !ack_r && ack_en) begin
            if (lat_cnt >= ack_lat) begin
                ack_r     <= 1'b1;
                mem_rdata <= model(mem_addr);
                lat_cnt   <= 0;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            ack_r <= 1'b0;
            if (!mem_req) lat_cnt <= 0;
        end
    end

    // Monitor: score responses, log grant order, count busy cycles.
    always @(negedge clk) begin
        resp_t r;
        if (if_gnt && d_gnt) overlap <= 1'b1;
        if (if_gnt || d_gnt) begin
            seq  <= {seq[6:0], if_gnt};
            gcnt <= gcnt + 1;
        end
        if (mem_req) reqcnt <= reqcnt + 1;
        if (err && !(if_rvalid || d_rvalid)) chk("err_without_rvalid", 1, 0);
        if (d_rvalid) begin
            if (exp_d.size() == 0) chk("d_unexpected_rvalid", 1, 0);
            else begin
                r = exp_d.pop_front();
                chk("d_rdata", rdata, r.data);
                chk("d_err", {63'd0, err}, {63'd0, r.err});
            end
        end
        if (if_rvalid) begin
            if (exp_if.size() == 0) chk("if_unexpected_rvalid", 1, 0);
            else begin
                r = exp_if.pop_front();
                chk("if_rdata", rdata, r.data);
                chk("if_err", {63'd0, err}, {63'd0, r.err});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic drive_d(input logic we, input logic [63:0] a, input logic [63:0] wd,
                           input bit push, input bit exp_err);
        bit got = 0;
        resp_t r;
        r.err  = exp_err;
        r.data = (exp_err || we) ? 64'd0 : model(a);
        if (push) exp_d.push_back(r);
        d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = d_gnt;
        end
        @(posedge clk); #1;
        d_req = 0;
        if (!got) begin
            chk("d_gnt_wait_expired", 0, 1);
        end else begin
            chk("d_mem_req", {63'd0, mem_req}, 64'd1);
            chk("d_mem_we", {63'd0, mem_we}, {63'd0, we});
            chk("d_mem_addr", mem_addr, a);
            chk("d_mem_wdata", mem_wdata, wd);
        end
    endtask

    task automatic drive_if(input logic [63:0] a);
        bit got = 0;
        resp_t r;
        r.err  = 0;
        r.data = model(a);
        exp_if.push_back(r);
        if_req = 1; if_addr = a;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = if_gnt;
        end
        @(posedge clk); #1;
        if_req = 0;
        if (!got) begin
            chk("if_gnt_wait_expired", 0, 1);
        end else begin
            chk("if_mem_req", {63'd0, mem_req}, 64'd1);
            chk("if_mem_we", {63'd0, mem_we}, 64'd0);
            chk("if_mem_addr", mem_addr, a);
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = (exp_if.size() == 0) && (exp_d.size() == 0) && !mem_req && !if_rvalid && !d_rvalid;
        end
        if (!done) chk("response_wait_expired", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int g0, r0;
        reset = 1; if_req = 1; if_addr = 64'h100; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; spur_ack = 0; ack_en = 1; ack_lat = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_gnt", {63'd0, if_gnt}, 0);
        chk("rst_mem_req", {63'd0, mem_req}, 0);
        chk("rst_rvalid", {62'd0, if_rvalid, d_rvalid}, 0);
        chk("rst_err", {63'd0, err}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        if_req = 0;
        @(posedge clk); #1;
        reset = 0;

        // Fetch only, ack a few cycles after mem_req.
        ack_lat = 1;
        drive_if(64'h100);
        wait_idle();
        ack_lat = 0;

        // Collision: data store wins, then fetch.
        g0 = gcnt;
        fork
            drive_d(1'b1, 64'h200, 64'hDEAD, 1, 0);
            drive_if(64'h300);
        join
        wait_idle();
        chk("collision_grants", gcnt - g0, 2);
        chk("collision_order", {62'd0, seq[1:0]}, 64'b01);

        // Continuous data pressure with a waiting fetch.
        g0 = gcnt;
        fork
            for (int k = 0; k < 5; k++) drive_d(1'b0, 64'h1000 + 64'(k * 8), 64'h0, 1, 0);
            drive_if(64'h2000);
        join
        wait_idle();
        chk("starve_grants", gcnt - g0, 6);
`ifdef ARB_STARVE_LIMIT_EN
        chk("starve_order", {58'd0, seq[5:0]}, 64'b000010);
`else
        chk("starve_order", {58'd0, seq[5:0]}, 64'b000001);
`endif

        // Timeout: no ack, mem_req held 8 cycles, error response.
        ack_en = 0;
        r0 = reqcnt;
        drive_d(1'b0, 64'h400, 64'h0, 1, 1);
        wait_idle();
        chk("timeout_req_cycles", reqcnt - r0, 8);
        ack_en = 1;

        // Reset during BUSY_D abandons the access.
        ack_en = 0;
        drive_d(1'b0, 64'h500, 64'h0, 0, 0);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("midrst_mem_req", {63'd0, mem_req}, 0);
        chk("midrst_d_rvalid", {63'd0, d_rvalid}, 0);
        repeat (12) @(posedge clk);
        #1;
        ack_en = 1;
        drive_d(1'b0, 64'h600, 64'h0, 1, 0);
        wait_idle();

        // Spurious ack in IDLE is ignored.
        spur_ack = 1;
        @(posedge clk); #1;
        spur_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("spur_mem_req", {63'd0, mem_req}, 0);
        drive_d(1'b1, 64'h700, 64'h1234, 1, 0);
        wait_idle();

        chk("grant_overlap", {63'd0, overlap}, 0);
        chk("exp_left", 64'(exp_if.size() + exp_d.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got=running exp=finished");
        $fatal(1);
    end

endmodule
